// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - in-order instruction fetch with tag FIFO, credit-limited requests and decode queue
// Optional same-cycle response bypass to decode when FETCH_BYPASS_EN is defined.
module fetch_buffer #(
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] currPC,
  output logic        halt,
  input  logic        flush,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc
);

  localparam int QPW = $clog2(DEPTH);
  localparam int QCW = QPW + 1;
  localparam int TPW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int OCW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int SW  = ((QCW > OCW) ? QCW : OCW) + 1;

  // decode queue
  logic [31:0]          q_instr_q [DEPTH];
  logic [31:0]          q_instr_d [DEPTH];
  logic [31:0]          q_pc_q    [DEPTH];
  logic [31:0]          q_pc_d    [DEPTH];
  logic [QPW-1:0]       q_head_q, q_head_d;
  logic [QPW-1:0]       q_tail_q, q_tail_d;
  logic [QCW-1:0]       q_cnt_q, q_cnt_d;

  // in-flight tag FIFO
  logic [31:0]          tag_pc_q [MAX_OUTSTANDING];
  logic [31:0]          tag_pc_d [MAX_OUTSTANDING];
  logic [MAX_OUTSTANDING-1:0] tag_live_q, tag_live_d;
  logic [TPW-1:0]       tag_wr_q, tag_wr_d;
  logic [TPW-1:0]       tag_rd_q, tag_rd_d;
  logic [OCW-1:0]       out_cnt_q, out_cnt_d;

  logic [SW-1:0] credit_sum;
  logic          credit_ok;
  logic          req_fire;
  logic          resp_take;
  logic          resp_live;
  logic          q_nonempty;
  logic          bypass;
  logic          q_push;
  logic          q_pop;

  // request issue, PC control and decode-side presentation
  always_comb begin
    credit_sum     = SW'(q_cnt_q) + SW'(out_cnt_q);
    credit_ok      = credit_sum < SW'(DEPTH);
    imem_req_valid = !reset && !flush && credit_ok && (out_cnt_q < OCW'(MAX_OUTSTANDING));
    imem_req_addr  = currPC;
    req_fire       = imem_req_valid && imem_req_ready;
    halt           = reset || (!flush && !req_fire);

    // responses with nothing outstanding are ignored; stale tags are dropped
    resp_take  = !reset && imem_resp_valid && (out_cnt_q != '0);
    resp_live  = resp_take && tag_live_q[tag_rd_q] && !flush;
    q_nonempty = (q_cnt_q != '0);
`ifdef FETCH_BYPASS_EN
    bypass     = resp_live && !q_nonempty;
`else
    bypass     = 1'b0;
`endif
    if_valid = q_nonempty || bypass;
    if_instr = bypass ? imem_resp_data : q_instr_q[q_head_q];
    if_pc    = bypass ? tag_pc_q[tag_rd_q] : q_pc_q[q_head_q];
    q_pop    = q_nonempty && if_ready && !flush;
    q_push   = resp_live && !(bypass && if_ready);
  end

  // next-state for the decode queue and the tag FIFO
  always_comb begin
    q_instr_d  = q_instr_q;
    q_pc_d     = q_pc_q;
    q_head_d   = q_head_q;
    q_tail_d   = q_tail_q;
    q_cnt_d    = q_cnt_q + QCW'(q_push) - QCW'(q_pop);
    tag_pc_d   = tag_pc_q;
    tag_live_d = tag_live_q;
    tag_wr_d   = tag_wr_q;
    tag_rd_d   = tag_rd_q;
    out_cnt_d  = out_cnt_q + OCW'(req_fire) - OCW'(resp_take);

    if (q_push) begin
      q_instr_d[q_tail_q] = imem_resp_data;
      q_pc_d[q_tail_q]    = tag_pc_q[tag_rd_q];
      q_tail_d            = q_tail_q + QPW'(1);
    end
    if (q_pop) begin
      q_head_d = q_head_q + QPW'(1);
    end
    if (req_fire) begin
      tag_pc_d[tag_wr_q]   = currPC;
      tag_live_d[tag_wr_q] = 1'b1;
      tag_wr_d = (tag_wr_q == TPW'(MAX_OUTSTANDING - 1)) ? '0 : tag_wr_q + TPW'(1);
    end
    if (resp_take) begin
      tag_rd_d = (tag_rd_q == TPW'(MAX_OUTSTANDING - 1)) ? '0 : tag_rd_q + TPW'(1);
    end
    // redirect empties the queue; in-flight slots stay allocated but go stale
    if (flush) begin
      q_head_d   = '0;
      q_tail_d   = '0;
      q_cnt_d    = '0;
      tag_live_d = '0;
    end
  end

  // state registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_instr_q[i] <= '0;
        q_pc_q[i]    <= '0;
      end
      q_head_q <= '0;
      q_tail_q <= '0;
      q_cnt_q  <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        tag_pc_q[i] <= '0;
      end
      tag_live_q <= '0;
      tag_wr_q   <= '0;
      tag_rd_q   <= '0;
      out_cnt_q  <= '0;
    end else begin
      q_instr_q  <= q_instr_d;
      q_pc_q     <= q_pc_d;
      q_head_q   <= q_head_d;
      q_tail_q   <= q_tail_d;
      q_cnt_q    <= q_cnt_d;
      tag_pc_q   <= tag_pc_d;
      tag_live_q <= tag_live_d;
      tag_wr_q   <= tag_wr_d;
      tag_rd_q   <= tag_rd_d;
      out_cnt_q  <= out_cnt_d;
    end
  end

  // a memory response with nothing outstanding is a protocol error
  assert property (@(posedge clk) disable iff (reset) !(imem_resp_valid && (out_cnt_q == '0)));

endmodule

// File: tb/tb_fetch_buffer.sv
// tb/tb_fetch_buffer.sv - directed scoreboard bench for fetch_buffer
module tb_fetch_buffer;

  localparam int DEPTH = 4;
  localparam int MO    = 2;

  logic        clk;
  logic        reset;
  logic [31:0] currPC;
  logic        halt;
  logic        flush;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  fetch_buffer #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MO)) dut (
    .clk(clk), .reset(reset), .currPC(currPC), .halt(halt), .flush(flush),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .if_pc(if_pc)
  );

  typedef struct { logic [31:0] addr; bit live; } pend_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;

  pend_t       pend[$];
  ent_t        sb[$];
  logic [31:0] dec_log[$];
  int          tests = 0;
  int          fails = 0;
  int          fire_cnt = 0;
  logic [31:0] last_fire_addr = '0;
  logic [31:0] next_pc = '0;
  logic [31:0] redirect = '0;
  bit          mem_hold = 0;
  logic [31:0] snap_pc;

  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a == 32'h20) ? 32'h00500093 : (32'hA5000000 ^ a);
  endfunction

  function automatic logic [31:0] dec_at(input int i);
    return (i < dec_log.size()) ? dec_log[i] : 32'hDEADBEEF;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // observe one cycle at the falling edge and update the reference model
  task automatic sample();
    bit   exp_rv, exp_iv, exp_halt, fire;
    pend_t p;
    ent_t  e;
    @(negedge clk);
    exp_rv = !flush && ((sb.size() + pend.size()) < DEPTH) && (pend.size() < MO);
    exp_iv = (sb.size() != 0);
    if (imem_resp_valid) begin
      p = pend.pop_front();
      if (p.live && !flush) begin
`ifdef FETCH_BYPASS_EN
        if (sb.size() == 0) exp_iv = 1;
`endif
        e.pc = p.addr;
        e.instr = instr_of(p.addr);
        sb.push_back(e);
      end
    end
    check("if_valid", {31'b0, if_valid}, {31'b0, exp_iv});
    if (exp_iv && if_ready && !flush && sb.size() != 0) begin
      e = sb.pop_front();
      check("if_pc", if_pc, e.pc);
      check("if_instr", if_instr, e.instr);
      dec_log.push_back(if_pc);
    end
    check("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_rv});
    fire = exp_rv && imem_req_ready;
    if (exp_rv) check("req_addr", imem_req_addr, currPC);
    exp_halt = !flush && !fire;
    check("halt", {31'b0, halt}, {31'b0, exp_halt});
    if (flush) begin
      foreach (pend[i]) pend[i].live = 0;
      sb.delete();
    end
    if (fire) begin
      p.addr = currPC;
      p.live = 1;
      pend.push_back(p);
      fire_cnt++;
      last_fire_addr = currPC;
    end
    next_pc = flush ? redirect : (halt ? currPC : currPC + 32'd4);
  endtask

  // step past the rising edge and drive the PC register and memory response
  task automatic advance();
    @(posedge clk);
    #1;
    currPC = next_pc;
    imem_resp_valid = !mem_hold && (pend.size() > 0);
    imem_resp_data  = imem_resp_valid ? instr_of(pend[0].addr) : 32'h0;
  endtask

  task automatic tick();
    sample();
    advance();
  endtask

  task automatic drain();
    imem_req_ready = 0;
    if_ready = 1;
    mem_hold = 0;
    repeat (8) tick();
  endtask

  initial begin
    reset = 1; currPC = 0; flush = 0; imem_req_ready = 0;
    imem_resp_valid = 0; imem_resp_data = 0; if_ready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check("rst_if_valid", {31'b0, if_valid}, 32'd0);
    check("rst_halt", {31'b0, halt}, 32'd1);
    check("rst_if_instr", if_instr, 32'd0);
    check("rst_if_pc", if_pc, 32'd0);
    @(posedge clk);
    #1;
    reset = 0;

    // in-order streaming from PC 0
    if_ready = 1; imem_req_ready = 1;
    repeat (5) tick();
    drain();
    check("t1_dec0", dec_at(0), 32'h0);
    check("t1_dec1", dec_at(1), 32'h4);
    check("t1_dec2", dec_at(2), 32'h8);

    // decode stalled: credits limit issue to DEPTH, one pop reopens one
    if_ready = 0; imem_req_ready = 1; fire_cnt = 0;
    repeat (8) tick();
    check("t2_fires_full", fire_cnt, DEPTH);
    if_ready = 1;
    tick();
    if_ready = 0; fire_cnt = 0;
    repeat (3) tick();
    check("t2_fires_reopen", fire_cnt, 32'd1);
    drain();

    // memory not ready for 3 cycles: PC held, then fires with same address
    snap_pc = currPC;
    repeat (3) begin
      tick();
      check("t3_pc_held", currPC, snap_pc);
    end
    imem_req_ready = 1; fire_cnt = 0;
    tick();
    check("t3_fire_cnt", fire_cnt, 32'd1);
    check("t3_fire_addr", last_fire_addr, snap_pc);
    drain();

    // two in flight, flush, redirect to 0x100
    currPC = 32'h10; mem_hold = 1; imem_req_ready = 1; if_ready = 1;
    dec_log.delete(); fire_cnt = 0;
    repeat (3) tick();
    check("t4_fires", fire_cnt, 32'd2);
    check("t4_last_addr", last_fire_addr, 32'h14);
    flush = 1; redirect = 32'h100;
    sample();
    check("t4_flush_halt", {31'b0, halt}, 32'd0);
    check("t4_flush_req", {31'b0, imem_req_valid}, 32'd0);
    advance();
    flush = 0; mem_hold = 0;
    repeat (6) tick();
    drain();
    check("t4_first_pc", dec_at(0), 32'h100);

    // simultaneous response, pop and fire with queue at 2
    if_ready = 0; imem_req_ready = 1;
    repeat (3) tick();
    check("t5_qcnt_before", dut.q_cnt_q, 32'd2);
    check("t5_out_before", dut.out_cnt_q, 32'd1);
    if_ready = 1;
    tick();
    check("t5_qcnt_after", dut.q_cnt_q, 32'd2);
    check("t5_out_after", dut.out_cnt_q, 32'd1);
    drain();

    // response at pc 0x20 into an empty queue
    currPC = 32'h20; if_ready = 1; imem_req_ready = 1;
    tick();
    imem_req_ready = 0;
    sample();
`ifdef FETCH_BYPASS_EN
    check("t6_bypass_valid", {31'b0, if_valid}, 32'd1);
    check("t6_bypass_pc", if_pc, 32'h20);
    check("t6_bypass_instr", if_instr, 32'h00500093);
    advance();
    check("t6_qcnt", dut.q_cnt_q, 32'd0);
`else
    check("t6_valid_early", {31'b0, if_valid}, 32'd0);
    advance();
    check("t6_qcnt", dut.q_cnt_q, 32'd1);
    sample();
    check("t6_valid_late", {31'b0, if_valid}, 32'd1);
    check("t6_instr", if_instr, 32'h00500093);
    check("t6_pc", if_pc, 32'h20);
    advance();
`endif
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
- Instruction-fetch stage directly downstream of the program counter register.
- Takes the current PC and issues in-order requests to instruction memory.
- Stores returned words with their PC in a small queue and presents them to decode with a valid/ready handshake.
- Drives the PC register's halt input, so the PC advances only when a fetch request is accepted, and supports flush on redirect.

Parameters:
- DEPTH, 4: instruction queue entries; power of 2, at least 2.
- MAX_OUTSTANDING, 2: maximum imem requests in flight; power of 2, at least 1.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- currPC  input  32  PC from the program counter register.
- halt  output  1  freeze the PC register this cycle.
- flush  input  1  redirect: discard all queued and in-flight fetches.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts the request.
- imem_req_addr  output  32  word address to fetch; always equals currPC.
- imem_resp_valid  input  1  response word valid; responses return in request order.
- imem_resp_data  input  32  fetched instruction.
- if_valid  output  1  instruction available to decode.
- if_ready  input  1  decode consumes this cycle.
- if_instr  output  32  instruction at the queue head.
- if_pc  output  32  PC of if_instr.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- While reset is high:
  - queue count, outstanding count, and all pointers are 0.
  - all in-flight tag valid bits are 0.
  - imem_req_valid=0, if_valid=0, halt=1.
  - if_instr and if_pc are 0.
- Credit check: credit_ok = (queue_count + outstanding) < DEPTH. Stale in-flight entries still consume credit.
- Request issue:
  - imem_req_valid = !reset & !flush & credit_ok & (outstanding < MAX_OUTSTANDING).
  - req_fire = imem_req_valid & imem_req_ready.
  - A fire pushes {currPC, live=1} into the in-flight tag FIFO (depth MAX_OUTSTANDING) and increments outstanding.
- PC control: halt = !flush & !req_fire.
  - The PC advances exactly once per accepted request.
  - On flush, halt=0, so the PC loads its redirect target in the same cycle.
- Response handling:
  - Each imem_resp_valid pops the tag FIFO and decrements outstanding.
  - If the popped tag is live and flush=0, {pc, instr} is written to the queue tail.
  - Otherwise the response is discarded.
  - A response with outstanding=0 is a protocol error and is ignored; simulation raises an assertion.
- Decode side:
  - if_valid = (queue_count != 0).
  - pop = if_valid & if_ready & !flush.
  - Latency: response to if_valid is 1 cycle (registered queue).
- Simultaneous events:
  - Push and pop in the same cycle leave queue_count unchanged.
  - Push at full cannot occur because of the credit rule.
  - req_fire and a response in the same cycle leave outstanding unchanged.
- flush (synchronous, one cycle):
  - Queue count is 0 and pointers are reset on the next edge.
  - All tag live bits are cleared; outstanding is not changed.
  - A response arriving in the flush cycle is discarded.
  - No request issues during flush; a new fetch of the redirect PC can issue on the next cycle.
- Pointers wrap modulo DEPTH or MAX_OUTSTANDING. Counters are log2(N)+1 bits wide.
- Reset mid-operation: all in-flight state is dropped immediately. Memory responses that arrive after reset deasserts are a system-level error, since memory is reset together with this block.

Optional Feature:
- FETCH_BYPASS_EN defined:
  - When queue_count=0 and a live, non-flushed response arrives, it drives if_valid/if_instr/if_pc combinationally in the same cycle.
  - If if_ready=1 that cycle, the entry is not enqueued; otherwise it is enqueued normally.
- FETCH_BYPASS_EN undefined: all responses go through the queue with 1-cycle latency.

Test Plan:
- Reset, then imem_req_ready=1 with 1-cycle response latency and currPC stepping 0x0, 0x4, 0x8 -> decode sees (0x0, i0), (0x4, i1), (0x8, i2) in order; halt=0 on each fire.
- if_ready=0, memory always ready -> exactly DEPTH=4 requests issue, then imem_req_valid=0 and halt=1 held; one pop reopens one credit.
- imem_req_ready=0 for 3 cycles -> halt=1 and currPC unchanged; the request fires on the 4th cycle with the same address.
- Two requests in flight (0x10, 0x14), flush, then PC redirected to 0x100 -> both responses discarded; first if_pc is 0x100; the flush cycle has halt=0 and imem_req_valid=0.
- Simultaneous response, if_ready pop, and req_fire with queue at 2 -> queue_count and outstanding are both unchanged next cycle.
- FETCH_BYPASS_EN, empty queue, response 0x00500093 at pc 0x20, if_ready=1 -> if_valid same cycle, queue_count stays 0. Without the macro, the same stimulus gives if_valid one cycle later.
